drive_sequencer: RTL

DRIVE_SEQUENCER -- requirements
Module: drive_sequencer

---
 rtl/drive_pkg.sv | 25 ++
 rtl/drive_sequencer_if.sv | 33 +++
 rtl/motor_ramp_channel.sv | 86 ++++++++
 rtl/drive_sequencer.sv | 101 ++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared types and default timing for the two-channel drive sequencer.
// Ramp arithmetic lives here so both channels step duty identically.
package drive_pkg;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_RUN,
    CH_RAMP_DOWN,
    CH_DEAD
  } ch_state_t;

  localparam int unsigned DEF_RAMP_DIV    = 100000;
  localparam int unsigned DEF_STEP        = 4;
  localparam int unsigned DEF_DEAD_CYCLES = 1000000;

  // Move cur toward tgt by at most step, landing exactly on tgt.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
    if (cur < tgt)      return ((tgt - cur) > step) ? cur + step : tgt;
    else if (cur > tgt) return ((cur - tgt) > step) ? cur - step : tgt;
    else                return cur;
  endfunction

endpackage

// File: rtl/drive_sequencer_if.sv
// Command/status bundle between the register block and the drive sequencer.
interface drive_sequencer_if;
  logic       cmd_en_r;
  logic       cmd_en_l;
  logic       cmd_dir_r;
  logic       cmd_dir_l;
  logic [7:0] cmd_duty_r;
  logic [7:0] cmd_duty_l;
  logic       cmd_update;
  logic       bump_hit;
  logic [7:0] PWM_DUTY_R;
  logic [7:0] PWM_DUTY_L;
  logic       PWM_EN_R;
  logic       PWM_EN_L;
  logic       PWM_DIR_R;
  logic       PWM_DIR_L;
  logic       fault;
  logic       busy;

  modport master (
    output cmd_en_r, cmd_en_l, cmd_dir_r, cmd_dir_l, cmd_duty_r, cmd_duty_l,
           cmd_update, bump_hit,
    input  PWM_DUTY_R, PWM_DUTY_L, PWM_EN_R, PWM_EN_L, PWM_DIR_R, PWM_DIR_L,
           fault, busy
  );

  modport slave (
    input  cmd_en_r, cmd_en_l, cmd_dir_r, cmd_dir_l, cmd_duty_r, cmd_duty_l,
           cmd_update, bump_hit,
    output PWM_DUTY_R, PWM_DUTY_L, PWM_EN_R, PWM_EN_L, PWM_DIR_R, PWM_DIR_L,
           fault, busy
  );
endinterface

// File: rtl/motor_ramp_channel.sv
// One motor side: soft-start ramp, ramp-down on reversal, dead-time hold.
module motor_ramp_channel
  import drive_pkg::*;
#(
  parameter int unsigned STEP        = DEF_STEP,
  parameter int unsigned DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       fault,
  input  logic       force_dead,
  input  logic [7:0] target,
  input  logic       cmd_dir,
  output logic [7:0] duty,
  output logic       en,
  output logic       dir,
  output ch_state_t  state
);

  localparam int unsigned   DW        = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES);
  localparam logic [7:0]    STEP_B    = 8'(STEP);

  logic [DW-1:0] dead_cnt;
  logic [7:0]    duty_dn;

  assign duty_dn = step_toward(duty, 8'd0, STEP_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CH_IDLE;
      duty     <= '0;
      en       <= 1'b0;
      dir      <= 1'b0;
      dead_cnt <= '0;
    end else if (force_dead) begin
      state    <= CH_DEAD;
      duty     <= '0;
      en       <= 1'b0;
      dead_cnt <= DEAD_LOAD;
    end else begin
      unique case (state)
        CH_IDLE: begin
          duty <= '0;
          en   <= 1'b0;
          if (target != '0 && !fault) begin
            dir   <= cmd_dir;
            en    <= 1'b1;
            state <= CH_RUN;
          end
        end
        CH_RUN: begin
          if (cmd_dir != dir && target != '0) begin
            state <= CH_RAMP_DOWN;
          end else if (duty == '0 && target == '0) begin
            en    <= 1'b0;
            state <= CH_IDLE;
          end else if (tick) begin
            duty <= step_toward(duty, target, STEP_B);
          end
        end
        // Drop straight into DEAD on the tick that reaches zero so en never
        // lingers high with zero duty.
        CH_RAMP_DOWN: begin
          if (duty == '0 || (tick && duty_dn == '0)) begin
            duty     <= '0;
            en       <= 1'b0;
            dead_cnt <= DEAD_LOAD;
            state    <= CH_DEAD;
          end else if (tick) begin
            duty <= duty_dn;
          end
        end
        CH_DEAD: begin
          duty <= '0;
          en   <= 1'b0;
          if (dead_cnt <= DW'(1)) state <= CH_IDLE;
          else                    dead_cnt <= dead_cnt - DW'(1);
        end
        default: state <= CH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/drive_sequencer.sv
// Two-channel drive sequencer: shared ramp prescaler, bump fault latch and
// one motor_ramp_channel per side.
module drive_sequencer
  import drive_pkg::*;
#(
  parameter int unsigned RAMP_DIV    = DEF_RAMP_DIV,
  parameter int unsigned STEP        = DEF_STEP,
  parameter int unsigned DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic       PCLK,
  input  logic       PRESERN,
  input  logic       cmd_en_r,
  input  logic       cmd_en_l,
  input  logic       cmd_dir_r,
  input  logic       cmd_dir_l,
  input  logic [7:0] cmd_duty_r,
  input  logic [7:0] cmd_duty_l,
  input  logic       cmd_update,
  input  logic       bump_hit,
  output logic [7:0] PWM_DUTY_R,
  output logic [7:0] PWM_DUTY_L,
  output logic       PWM_EN_R,
  output logic       PWM_EN_L,
  output logic       PWM_DIR_R,
  output logic       PWM_DIR_L,
  output logic       fault,
  output logic       busy
);

  localparam int unsigned   PW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          bump_q;
  logic          bump_rise;
  logic [7:0]    target_r;
  logic [7:0]    target_l;
  ch_state_t     state_r;
  ch_state_t     state_l;

  assign tick      = (pre_cnt == PRE_LAST);
  assign bump_rise = bump_hit & ~bump_q;
  assign target_r  = cmd_en_r ? cmd_duty_r : '0;
  assign target_l  = cmd_en_l ? cmd_duty_l : '0;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) pre_cnt <= '0;
    else          pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
  end

  // A new bump outranks a same-cycle clearing write.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      bump_q <= 1'b0;
      fault  <= 1'b0;
    end else begin
      bump_q <= bump_hit;
      if (bump_rise)                   fault <= 1'b1;
      else if (cmd_update && !bump_hit) fault <= 1'b0;
    end
  end

  motor_ramp_channel #(
    .STEP        (STEP),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_ch_r (
    .clk        (PCLK),
    .rst_n      (PRESERN),
    .tick       (tick),
    .fault      (fault),
    .force_dead (bump_rise),
    .target     (target_r),
    .cmd_dir    (cmd_dir_r),
    .duty       (PWM_DUTY_R),
    .en         (PWM_EN_R),
    .dir        (PWM_DIR_R),
    .state      (state_r)
  );

  motor_ramp_channel #(
    .STEP        (STEP),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_ch_l (
    .clk        (PCLK),
    .rst_n      (PRESERN),
    .tick       (tick),
    .fault      (fault),
    .force_dead (bump_rise),
    .target     (target_l),
    .cmd_dir    (cmd_dir_l),
    .duty       (PWM_DUTY_L),
    .en         (PWM_EN_L),
    .dir        (PWM_DIR_L),
    .state      (state_l)
  );

  assign busy = (state_r inside {CH_RAMP_DOWN, CH_DEAD}) ||
                (state_l inside {CH_RAMP_DOWN, CH_DEAD});

endmodule
